// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/ack bus between the fetch sequencer and imem.
// The fetch side holds imem_addr steady until it sees imem_ack.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem handshake, applies redirects
// and feeds decode through a one-deep slot backed by a one-entry skid buffer.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_op,
  input  logic [31:0]        redirect_pc,
  input  logic [25:0]        redirect_imm,
  input  logic [31:0]        redirect_ra,
  input  logic               exc_valid,
  pc_fetch_ctrl_if.master    imem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc4,
  output logic [31:0]        if_instr,
  output logic               addr_err
);

  typedef enum logic [1:0] {BOOT, FETCH, SKID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_pend_q, kill_pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_d, addr_err_d;
  logic [31:0] if_pc_d, if_pc4_d, if_instr_d;

  logic        redirect_take, jr_misaligned, any_redirect, slot_free;
  logic [31:0] branch_target, jump_target, target;

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  // Redirect target decode; an exception or a misaligned jr both land on EXC_VEC.
  always_comb begin
    redirect_take = redirect_valid && (redirect_op != 2'b00);
    branch_target = redirect_pc + 32'd4 +
                    {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
    jump_target   = {redirect_pc[31:28], redirect_imm, 2'b00};
    jr_misaligned = redirect_take && (redirect_op == 2'b11) &&
                    (redirect_ra[1:0] != 2'b00);
    any_redirect  = exc_valid || redirect_take;
    case (redirect_op)
      2'b01:   target = branch_target;
      2'b10:   target = jump_target;
      default: target = redirect_ra;
    endcase
    if (exc_valid || jr_misaligned)
      target = EXC_VEC;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_pend_d   = kill_pend_q;
    pend_target_d = pend_target_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_valid_d    = if_valid;
    if_pc_d       = if_pc;
    if_pc4_d      = if_pc4;
    if_instr_d    = if_instr;
    addr_err_d    = jr_misaligned && !exc_valid;
    slot_free     = !if_valid || !stall;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (any_redirect)
          pc_d = target;
      end
      FETCH: begin
        if (!stall)
          if_valid_d = 1'b0;
        if (any_redirect) begin
          // Without an ack the old address must stay on the bus, so park the target.
          if_valid_d = 1'b0;
          if (imem.imem_ack) begin
            pc_d        = target;
            kill_pend_d = 1'b0;
          end else begin
            kill_pend_d   = 1'b1;
            pend_target_d = target;
          end
        end else if (imem.imem_ack) begin
          if (kill_pend_q) begin
            pc_d        = pend_target_q;
            kill_pend_d = 1'b0;
          end else if (slot_free) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + 32'd4;
            if_instr_d = imem.imem_rdata;
            pc_d       = pc_q + 32'd4;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_rdata;
            pc_d         = pc_q + 32'd4;
            state_d      = SKID;
          end
        end
      end
      SKID: begin
        if (any_redirect) begin
          pc_d       = target;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_pc4_d   = skid_pc_q + 32'd4;
          if_instr_d = skid_instr_q;
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      kill_pend_q   <= 1'b0;
      pend_target_q <= 32'd0;
      skid_pc_q     <= 32'd0;
      skid_instr_q  <= 32'd0;
      if_valid      <= 1'b0;
      if_pc         <= 32'd0;
      if_pc4        <= 32'd0;
      if_instr      <= 32'd0;
      addr_err      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_pend_q   <= kill_pend_d;
      pend_target_q <= pend_target_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_valid      <= if_valid_d;
      if_pc         <= if_pc_d;
      if_pc4        <= if_pc4_d;
      if_instr      <= if_instr_d;
      addr_err      <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vectors, a queue-based model of
// the instruction stream compared every cycle, plus hand-computed literal checks.
module tb_pc_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, exc_valid, ack;
  logic [1:0]  redirect_op;
  logic [31:0] redirect_pc, redirect_ra;
  logic [25:0] redirect_imm;
  logic        if_valid, addr_err;
  logic [31:0] if_pc, if_pc4, if_instr;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_op(redirect_op),
    .redirect_pc(redirect_pc), .redirect_imm(redirect_imm),
    .redirect_ra(redirect_ra), .exc_valid(exc_valid),
    .imem(bus.master),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_instr(if_instr), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = memWord(bus.imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most two instructions held between slot and skid; fetch pauses
  // while both are held; a redirect empties everything and retargets fetch.
  entry_t      q[$];
  logic        boot, pend, m_err;
  logic [31:0] next_addr, pend_t;

  function automatic logic [31:0] modelTarget();
    int signed off;
    off = $signed(redirect_imm[15:0]);
    if (exc_valid) return 32'h0000_4180;
    case (redirect_op)
      2'b01:   return redirect_pc + 32'd4 + 32'(off * 4);
      2'b10:   return (redirect_pc & 32'hF000_0000) | ({6'b0, redirect_imm} << 2);
      default: return (redirect_ra[1:0] != 2'b00) ? 32'h0000_4180 : redirect_ra;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot = 1'b1; q.delete(); next_addr = 32'h0000_3000;
      pend = 1'b0; pend_t = 32'd0; m_err = 1'b0;
    end else begin
      logic req_m, ack_m, take, redir;
      logic [31:0] tgt;
      req_m = !boot && (q.size() < 2);
      ack_m = req_m && ack;
      take  = redirect_valid && (redirect_op != 2'b00);
      redir = exc_valid || take;
      tgt   = modelTarget();
      m_err = take && !exc_valid && (redirect_op == 2'b11) && (redirect_ra[1:0] != 2'b00);
      if (q.size() > 0 && !stall) void'(q.pop_front());
      if (redir) begin
        q.delete();
        if (ack_m || !req_m) begin
          next_addr = tgt; pend = 1'b0;
        end else begin
          pend = 1'b1; pend_t = tgt;
        end
      end else if (ack_m) begin
        if (pend) begin
          next_addr = pend_t; pend = 1'b0;
        end else begin
          q.push_back({next_addr, memWord(next_addr)});
          next_addr = next_addr + 32'd4;
        end
      end
      boot = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_req;
    exp_req = rst_n && !boot && (q.size() < 2);
    checkOutput("model_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    if (exp_req) checkOutput("model_addr", bus.imem_addr, next_addr);
    checkOutput("model_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      checkOutput("model_pc", if_pc, q[0].pc);
      checkOutput("model_pc4", if_pc4, q[0].pc + 32'd4);
      checkOutput("model_instr", if_instr, q[0].instr);
    end
    checkOutput("model_err", {31'd0, addr_err}, {31'd0, m_err && rst_n});
  end

  task automatic applyStimulus(input logic s, input logic rv, input logic [1:0] op,
                               input logic [31:0] rpc, input logic [25:0] imm,
                               input logic [31:0] ra, input logic exc, input logic a);
    @(negedge clk);
    stall = s; redirect_valid = rv; redirect_op = op; redirect_pc = rpc;
    redirect_imm = imm; redirect_ra = ra; exc_valid = exc; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic s, input logic a);
    applyStimulus(s, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, a);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_op = 2'b00;
    redirect_pc = 32'd0; redirect_imm = 26'd0; redirect_ra = 32'd0;
    exc_valid = 1'b0; ack = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_pc", if_pc, 32'd0);
    checkOutput("rst_pc4", if_pc4, 32'd0);
    checkOutput("rst_instr", if_instr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("boot_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("boot_addr", bus.imem_addr, 32'h0000_3000);

    idle(1'b0, 1'b1);
    checkOutput("first_pc", if_pc, 32'h0000_3000);
    checkOutput("first_pc4", if_pc4, 32'h0000_3004);
    checkOutput("first_instr", if_instr, 32'hC0DE_3000);
    idle(1'b0, 1'b1);
    checkOutput("second_pc", if_pc, 32'h0000_3004);
    idle(1'b0, 1'b1);
    checkOutput("third_pc", if_pc, 32'h0000_3008);

    // Branch back by two words, acked in the same cycle.
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_3008, 26'h000FFFE, 32'd0, 1'b0, 1'b1);
    checkOutput("br_addr", bus.imem_addr, 32'h0000_3004);
    checkOutput("br_flush", {31'd0, if_valid}, 32'd0);

    // Jump issued while the fetch is still waiting for its ack.
    idle(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_3010, 26'h0000C40, 32'd0, 1'b0, 1'b0);
    checkOutput("kill_addr_hold", bus.imem_addr, 32'h0000_3004);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    checkOutput("kill_addr", bus.imem_addr, 32'h0000_3100);
    checkOutput("kill_no_stale", {31'd0, if_valid}, 32'd0);
    idle(1'b0, 1'b1);
    checkOutput("kill_first_pc", if_pc, 32'h0000_3100);

    // Stall with a full slot pushes the next word into the skid buffer.
    idle(1'b1, 1'b1);
    checkOutput("skid_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("skid_hold_pc", if_pc, 32'h0000_3100);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("skid_drain_pc", if_pc, 32'h0000_3104);
    checkOutput("skid_resume_addr", bus.imem_addr, 32'h0000_3108);
    idle(1'b0, 1'b1);
    checkOutput("skid_next_pc", if_pc, 32'h0000_3108);

    // Misaligned jr, then exception racing a branch.
    applyStimulus(1'b0, 1'b1, 2'b11, 32'd0, 26'd0, 32'h0000_3002, 1'b0, 1'b1);
    checkOutput("jr_mis_addr", bus.imem_addr, 32'h0000_4180);
    checkOutput("jr_mis_err", {31'd0, addr_err}, 32'd1);
    idle(1'b0, 1'b1);
    checkOutput("jr_err_once", {31'd0, addr_err}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_5000, 26'h0000010, 32'd0, 1'b1, 1'b1);
    checkOutput("exc_wins", bus.imem_addr, 32'h0000_4180);
    checkOutput("exc_no_err", {31'd0, addr_err}, 32'd0);

    // Aligned jr, then a redirect while parked in the skid state under stall.
    applyStimulus(1'b0, 1'b1, 2'b11, 32'd0, 26'd0, 32'h0000_3200, 1'b0, 1'b1);
    checkOutput("jr_addr", bus.imem_addr, 32'h0000_3200);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h0000_3000, 26'h0000C80, 32'd0, 1'b0, 1'b1);
    checkOutput("skid_redir_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("skid_redir_addr", bus.imem_addr, 32'h0000_3200);

    // PC wraps past the top of the address space.
    applyStimulus(1'b0, 1'b1, 2'b11, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("wrap_pc4", if_pc4, 32'd0);
    checkOutput("wrap_addr", bus.imem_addr, 32'd0);

    // Asynchronous reset in the middle of an outstanding fetch.
    idle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("arst_valid", {31'd0, if_valid}, 32'd0);
    ack = 1'b1; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("arst_restart", bus.imem_addr, 32'h0000_3000);
    idle(1'b0, 1'b1);
    checkOutput("arst_first_pc", if_pc, 32'h0000_3000);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
